// File: rtl/xorshift_stream_checker_pkg.sv
// Shared xorshift32 definitions (a=13, b=17, c=5) for the stream generator and checker.
// Holds the shift constants, the checker state encoding and the combinational step().
package xorshift_stream_checker_pkg;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CHECK = 2'd1;
  localparam state_t DONE  = 2'd2;

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction

endpackage

// File: rtl/xorshift32_step.sv
// One combinational xorshift32 step; a thin wrapper so the checker has a single step instance.
module xorshift32_step
  import xorshift_stream_checker_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = step(x);

endmodule

// File: rtl/xorshift_stream_checker.sv
// Receive-side xorshift32 stream checker: regenerates the sequence per seed and reports pass/fail.
// Optional first-mismatch capture ports are enabled with the CHK_FIRST_MISMATCH_EN macro.
module xorshift_stream_checker
  import xorshift_stream_checker_pkg::*;
#(
  parameter int NUM_PER_SEED = 256,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  input  logic [31:0]      rand_num,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] stray_cnt,
  output logic             mismatch,
`ifdef CHK_FIRST_MISMATCH_EN
  output logic [CNT_W-1:0] first_idx,
  output logic [31:0]      first_got,
  output logic [31:0]      first_exp,
`endif
  output state_t           state_dbg
);

  // Input handshake: seed_valid is a one-cycle strobe accepted only in IDLE; in_valid
  // qualifies rand_num each cycle with no backpressure. Words outside CHECK are stray.

  state_t           state;
  logic [31:0]      exp_reg;
  logic [31:0]      step_in;
  logic [31:0]      step_out;
  logic [CNT_W-1:0] word_cnt;
  logic             take;
  logic             bad;
  logic             last;

  // One step instance serves both seed load (IDLE) and sequence advance (CHECK).
  assign step_in = (state == IDLE) ? seed : exp_reg;

  xorshift32_step u_step (
    .x (step_in),
    .y (step_out)
  );

  assign take = (state == CHECK) && in_valid;
  assign bad  = take && (rand_num != exp_reg);
  assign last = (word_cnt == CNT_W'(NUM_PER_SEED - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_reg  <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_valid) begin
            exp_reg  <= step_out;
            word_cnt <= '0;
            err_cnt  <= '0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (in_valid) begin
            exp_reg  <= step_out;
            word_cnt <= word_cnt + CNT_W'(1);
            if (bad && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            if (last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch  <= 1'b0;
      stray_cnt <= '0;
    end else begin
      mismatch <= bad;
      if (in_valid && (state != CHECK) && (stray_cnt != '1))
        stray_cnt <= stray_cnt + CNT_W'(1);
    end
  end

`ifdef CHK_FIRST_MISMATCH_EN
  // err_cnt is still zero on the first bad word of a seed, so no separate flag is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if ((state == IDLE) && seed_valid) begin
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if (bad && (err_cnt == '0)) begin
      first_idx <= word_cnt;
      first_got <= rand_num;
      first_exp <= exp_reg;
    end
  end
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_cnt == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Self-checking bench for xorshift_stream_checker against an arithmetic xorshift32 reference model.
// Build with CHK_FIRST_MISMATCH_EN defined to also exercise the first-mismatch capture ports.
module tb_xorshift_stream_checker;

  localparam int N     = 256;
  localparam int CNT_W = 9;

  logic             clk;
  logic             rst_n;
  logic             seed_valid;
  logic [31:0]      seed;
  logic             in_valid;
  logic [31:0]      rand_num;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] stray_cnt;
  logic             mismatch;
  logic [1:0]       state_dbg;
`ifdef CHK_FIRST_MISMATCH_EN
  logic [CNT_W-1:0] first_idx;
  logic [31:0]      first_got;
  logic [31:0]      first_exp;
`endif

  int checks = 0;
  int errors = 0;
  int exp_stray = 0;
  logic [31:0] exp_q[$];

  xorshift_stream_checker #(.NUM_PER_SEED(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .in_valid   (in_valid),
    .rand_num   (rand_num),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .stray_cnt  (stray_cnt),
    .mismatch   (mismatch),
`ifdef CHK_FIRST_MISMATCH_EN
    .first_idx  (first_idx),
    .first_got  (first_got),
    .first_exp  (first_exp),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference xorshift32 step written as modular multiply/divide instead of shifts.
  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x * 32'd8192);
    y = y ^ (y / 32'd131072);
    y = y ^ (y * 32'd32);
    return y;
  endfunction

  // Runs one seed. bad_a/bad_b: word indices to corrupt (-1 none); inj_idx: word at which
  // a foreign seed strobe is injected; abort_at: word at which reset is asserted instead.
  task automatic run_seed(input logic [31:0] s, input int bad_a, input int bad_b,
                          input int max_gap, input int inj_idx, input bit stray_in_done,
                          input bit stray_with_seed, input int abort_at);
    logic [31:0] r;
    logic [31:0] w;
    int errs;
    int g;
    bit is_bad;
    bit is_last;
    int fi_idx;
    logic [31:0] fi_got;
    logic [31:0] fi_exp;
    fi_idx = -1;
    fi_got = '0;
    fi_exp = '0;
    errs = 0;
    // Expected sequence for this seed.
    exp_q.delete();
    r = s;
    for (int i = 0; i < N; i++) begin
      r = ref_step(r);
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
    seed_valid = 1'b1;
    seed = s;
    in_valid = stray_with_seed;
    rand_num = $urandom;
    if (stray_with_seed) exp_stray++;
    @(posedge clk); #1;
    seed_valid = 1'b0;
    in_valid = 1'b0;
    seed = $urandom;
    checks++;
    if ({busy, done, pass, err_cnt} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL seed_accept: busy/done/pass/err=%b%b%b/%0d want 100/0", busy, done, pass, err_cnt);
    end
    checks++;
    if (stray_cnt !== CNT_W'(exp_stray)) begin
      errors++;
      $display("FAIL stray_at_seed: stray_cnt=%0d want %0d", stray_cnt, exp_stray);
    end
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_stray = 0;
        checks++;
        if ({busy, done, pass, mismatch, err_cnt, stray_cnt} !== '0) begin
          errors++;
          $display("FAIL reset_mid: busy=%b done=%b pass=%b mm=%b err=%0d stray=%0d want all 0",
                   busy, done, pass, mismatch, err_cnt, stray_cnt);
        end
        #2;
        rst_n = 1'b1;
        return;
      end
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        checks++;
        if ({mismatch, done, busy} !== 3'b001) begin
          errors++;
          $display("FAIL gap: mm/done/busy=%b%b%b want 001 at word %0d", mismatch, done, busy, i);
        end
      end
      w = exp_q.pop_front();
      is_bad = (i == bad_a) || (i == bad_b);
      in_valid = 1'b1;
      rand_num = is_bad ? (w ^ 32'h1) : w;
      if (is_bad && fi_idx < 0) begin
        fi_idx = i;
        fi_got = w ^ 32'h1;
        fi_exp = w;
      end
      if (i == inj_idx) begin
        seed_valid = 1'b1;
        seed = s ^ 32'h5a5a_5a5a;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      seed_valid = 1'b0;
      if (is_bad) errs++;
      is_last = (i == N - 1);
      checks++;
      if (mismatch !== is_bad) begin
        errors++;
        $display("FAIL mismatch_pulse: word %0d mismatch=%b want %b", i, mismatch, is_bad);
      end
      checks++;
      if (err_cnt !== CNT_W'(errs)) begin
        errors++;
        $display("FAIL err_cnt: word %0d err_cnt=%0d want %0d", i, err_cnt, errs);
      end
      checks++;
      if ({done, pass, busy} !== {is_last, is_last && (errs == 0), 1'b1}) begin
        errors++;
        $display("FAIL done_pass: word %0d done/pass/busy=%b%b%b want %b%b1", i, done, pass, busy,
                 is_last, is_last && (errs == 0));
      end
    end
`ifdef CHK_FIRST_MISMATCH_EN
    checks++;
    if ({first_idx, first_got, first_exp} !== {CNT_W'(fi_idx < 0 ? 0 : fi_idx), fi_got, fi_exp}) begin
      errors++;
      $display("FAIL first_capture: idx=%0d got=%h exp=%h want idx=%0d got=%h exp=%h",
               first_idx, first_got, first_exp, fi_idx, fi_got, fi_exp);
    end
`endif
    // Currently in the DONE cycle.
    if (stray_in_done) begin
      in_valid = 1'b1;
      rand_num = $urandom;
      exp_stray++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({done, pass, busy, err_cnt} !== {3'b000, CNT_W'(errs)}) begin
      errors++;
      $display("FAIL after_done: done/pass/busy=%b%b%b err=%0d want 000/%0d", done, pass, busy, err_cnt, errs);
    end
    checks++;
    if (stray_cnt !== CNT_W'(exp_stray)) begin
      errors++;
      $display("FAIL stray_after_done: stray_cnt=%0d want %0d", stray_cnt, exp_stray);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seed_valid = 1'b0;
    seed = '0;
    in_valid = 1'b0;
    rand_num = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, mismatch, err_cnt, stray_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b mm=%b err=%0d stray=%0d want all 0",
               busy, done, pass, mismatch, err_cnt, stray_cnt);
    end
`ifdef CHK_FIRST_MISMATCH_EN
    checks++;
    if ({first_idx, first_got, first_exp} !== '0) begin
      errors++;
      $display("FAIL reset_first: idx=%0d got=%h exp=%h want 0", first_idx, first_got, first_exp);
    end
`endif
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_first_word();
    checks++;
    if (ref_step(32'h1) !== 32'h0004_2021) begin
      errors++;
      $display("FAIL ref_first_word: got %h want 00042021", ref_step(32'h1));
    end
  endtask

  task automatic test_stray();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      rand_num = $urandom;
      exp_stray++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({busy, stray_cnt} !== {1'b0, CNT_W'(3)}) begin
      errors++;
      $display("FAIL stray_idle: busy=%b stray_cnt=%0d want 0/3", busy, stray_cnt);
    end
    run_seed(32'h1, -1, -1, 0, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++)
      run_seed($urandom | 32'h1, $urandom_range(0, N - 1), $urandom_range(0, N - 1), 2, -1,
               1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_stray();
    run_seed(32'h1, -1, -1, 0, -1, 1'b0, 1'b0, -1);          // clean back-to-back run
    run_seed(32'h1, 10, -1, 0, -1, 1'b0, 1'b0, -1);          // single corrupted word
    run_seed(32'h1, -1, -1, 5, -1, 1'b0, 1'b0, -1);          // random gaps
    run_seed(32'h1, -1, -1, 0, 50, 1'b1, 1'b0, -1);          // ignored seed, stray in DONE
    run_seed(32'h1234_5678, -1, -1, 0, -1, 1'b0, 1'b1, -1);  // stray alongside seed strobe
    run_seed(32'h1, 5, 9, 0, -1, 1'b0, 1'b0, -1);            // two bad words
    run_seed(32'h1, -1, -1, 0, -1, 1'b0, 1'b0, 100);         // reset mid-check
    run_seed(32'hDEAD_BEEF, -1, -1, 0, -1, 1'b0, 1'b0, -1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
